// File: rtl/pcs_64b66b_pkg.sv
// Shared constants and helpers for the 64b/66b PCS receive path.
// Holds sync header codes, control block types, XGMII control characters,
// the 7-bit control characters carried in idle blocks, and the block-lock
// FSM state type.
package pcs_64b66b_pkg;

  // Sync headers
  localparam logic [1:0] D_HDR    = 2'b10;
  localparam logic [1:0] CTRL_HDR = 2'b01;

  // Control block types
  localparam logic [7:0] BT_IDLE  = 8'h1E;
  localparam logic [7:0] BT_START = 8'h78;
  localparam logic [7:0] BT_SEQ   = 8'h4B;
  localparam logic [7:0] BT_TERM0 = 8'h87;
  localparam logic [7:0] BT_TERM1 = 8'h99;
  localparam logic [7:0] BT_TERM2 = 8'hAA;
  localparam logic [7:0] BT_TERM3 = 8'hB4;
  localparam logic [7:0] BT_TERM4 = 8'hCC;
  localparam logic [7:0] BT_TERM5 = 8'hD2;
  localparam logic [7:0] BT_TERM6 = 8'hE1;
  localparam logic [7:0] BT_TERM7 = 8'hFF;

  // XGMII control characters
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_LPI   = 8'h06;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  // 7-bit control characters inside idle blocks
  localparam logic [6:0] C7_IDLE  = 7'h00;
  localparam logic [6:0] C7_LPI   = 7'h06;
  localparam logic [6:0] C7_ERROR = 7'h1E;

  typedef enum logic [1:0] {
    LK_HUNT,
    LK_SLIP_WT,
    LK_LOCKED
  } lock_state_e;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == D_HDR) || (hdr == CTRL_HDR);
  endfunction

  // Number of data octets preceding /T/ for a terminate block type;
  // 8 means the type is not a terminate.
  function automatic int unsigned term_len(input logic [7:0] bt);
    case (bt)
      BT_TERM0: return 0;
      BT_TERM1: return 1;
      BT_TERM2: return 2;
      BT_TERM3: return 3;
      BT_TERM4: return 4;
      BT_TERM5: return 5;
      BT_TERM6: return 6;
      BT_TERM7: return 7;
      default:  return 8;
    endcase
  endfunction

endpackage

// File: rtl/pcs_block_lock.sv
// Block-lock acquisition and monitoring on 64b/66b sync headers.
// Ports:
//   clk, rst        receive clock, async active-high reset
//   blk_valid       a block is accepted this cycle
//   sync_hdr        sync header of the accepted block
//   block_lock      high while in the LOCKED state
//   slip            one-cycle bit-slip request to the gearbox
module pcs_block_lock
  import pcs_64b66b_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned BAD_SH_MAX = 16,
  parameter int unsigned SLIP_WAIT  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blk_valid,
  input  logic [1:0] sync_hdr,
  output logic       block_lock,
  output logic       slip
);

  localparam int unsigned SH_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  localparam int unsigned BAD_W = $clog2(BAD_SH_MAX + 1);
  localparam int unsigned SW_W  = $clog2(SLIP_WAIT + 1);

  lock_state_e      state_q, state_d;
  logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [BAD_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [SW_W-1:0]  slip_cnt_q, slip_cnt_d;
  logic             block_lock_q, block_lock_d;
  logic             slip_q, slip_d;
  logic             hdr_ok;

  assign hdr_ok     = hdr_is_valid(sync_hdr);
  assign block_lock = block_lock_q;
  assign slip       = slip_q;

  // Counters are compared against THRESHOLD-1 on the current value so the
  // transition happens on the block that makes the count reach THRESHOLD.
  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    block_lock_d = block_lock_q;
    slip_d       = 1'b0;   // SLIP always falls after one cycle
    if (blk_valid) begin
      case (state_q)
        LK_HUNT: begin
          if (hdr_ok) begin
            if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
              state_d      = LK_LOCKED;
              block_lock_d = 1'b1;
              sh_cnt_d     = '0;
              win_cnt_d    = '0;
              bad_cnt_d    = '0;
            end else begin
              sh_cnt_d = sh_cnt_q + 1'b1;
            end
          end else begin
            state_d    = LK_SLIP_WT;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            slip_cnt_d = '0;
          end
        end
        LK_SLIP_WT: begin
          if (slip_cnt_q == SW_W'(SLIP_WAIT - 1)) begin
            state_d    = LK_HUNT;
            slip_cnt_d = '0;
          end else begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
        end
        LK_LOCKED: begin
          // Loss of lock takes priority over the window wrap.
          if (!hdr_ok && bad_cnt_q == BAD_W'(BAD_SH_MAX - 1)) begin
            state_d      = LK_HUNT;
            block_lock_d = 1'b0;
            slip_d       = 1'b1;
            sh_cnt_d     = '0;
            win_cnt_d    = '0;
            bad_cnt_d    = '0;
          end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (!hdr_ok) begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = LK_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LK_HUNT;
      sh_cnt_q     <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      block_lock_q <= 1'b0;
      slip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      block_lock_q <= block_lock_d;
      slip_q       <= slip_d;
    end
  end

endmodule

// File: rtl/pcs_rx_decoder.sv
// Single-lane 64b/66b receive PCS decoder.
// Ports:
//   RX_CLK, RST       receive clock, async active-high reset
//   RX_BLOCK          66-bit descrambled block ([1:0] header, [9:2] type)
//   RX_BLOCK_VALID    RX_BLOCK is accepted this cycle
//   RXD, RX_C         decoded XGMII octets and per-lane control flags
//   RX_VALID          one-cycle strobe per accepted block
//   BLOCK_LOCK        block lock achieved
//   SLIP              one-cycle bit-slip request to the gearbox
//   ERR_CNT           saturating count of errored blocks while locked
module pcs_rx_decoder
  import pcs_64b66b_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned BAD_SH_MAX = 16,
  parameter int unsigned SLIP_WAIT  = 32
) (
  input  logic        RX_CLK,
  input  logic        RST,
  input  logic [65:0] RX_BLOCK,
  input  logic        RX_BLOCK_VALID,
  output logic [63:0] RXD,
  output logic [7:0]  RX_C,
  output logic        RX_VALID,
  output logic        BLOCK_LOCK,
  output logic        SLIP,
  output logic [15:0] ERR_CNT
);

  logic        block_lock;
  logic [63:0] rxd_q, rxd_d;
  logic [7:0]  rx_c_q, rx_c_d;
  logic        rx_valid_q, rx_valid_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [63:0] dec_data;
  logic [7:0]  dec_ctrl;
  logic        dec_err;
  logic [6:0]  c7;
  logic [63:0] pay_ext;
  int unsigned t_n;

  pcs_block_lock #(
    .LOCK_CNT  (LOCK_CNT),
    .WINDOW    (WINDOW),
    .BAD_SH_MAX(BAD_SH_MAX),
    .SLIP_WAIT (SLIP_WAIT)
  ) u_lock (
    .clk       (RX_CLK),
    .rst       (RST),
    .blk_valid (RX_BLOCK_VALID),
    .sync_hdr  (RX_BLOCK[1:0]),
    .block_lock(block_lock),
    .slip      (SLIP)
  );

  // Payload zero-extended to 64 bits so octet selects never run off the end.
  assign pay_ext = {8'h00, RX_BLOCK[65:10]};

  always_comb begin
    dec_data = {8{XG_ERROR}};
    dec_ctrl = '1;
    dec_err  = 1'b0;
    c7       = '0;
    t_n      = term_len(RX_BLOCK[9:2]);
    if (RX_BLOCK[1:0] == D_HDR) begin
      dec_data = RX_BLOCK[65:2];
      dec_ctrl = '0;
    end else if (RX_BLOCK[1:0] == CTRL_HDR) begin
      case (RX_BLOCK[9:2])
        BT_IDLE: begin
          for (int unsigned k = 0; k < 8; k++) begin
            c7 = RX_BLOCK[10 + 7*k +: 7];
            case (c7)
              C7_IDLE:  dec_data[8*k +: 8] = XG_IDLE;
              C7_LPI:   dec_data[8*k +: 8] = XG_LPI;
              C7_ERROR: dec_data[8*k +: 8] = XG_ERROR;
              default: begin
                dec_data[8*k +: 8] = XG_ERROR;
                dec_err            = 1'b1;
              end
            endcase
          end
          dec_ctrl = '1;
        end
        BT_START: begin
          dec_data = {RX_BLOCK[65:10], XG_START};
          dec_ctrl = 8'h01;
        end
        BT_SEQ: begin
          dec_data = {32'h0, RX_BLOCK[33:10], XG_SEQ};
          dec_ctrl = 8'h01;
        end
        default: begin
          if (t_n < 8) begin
            for (int unsigned k = 0; k < 8; k++) begin
              if (k < t_n) begin
                dec_data[8*k +: 8] = pay_ext[8*k +: 8];
              end else if (k == t_n) begin
                dec_data[8*k +: 8] = XG_TERM;
              end else begin
                dec_data[8*k +: 8] = XG_IDLE;
              end
            end
            dec_ctrl = 8'hFF << t_n;
          end else begin
            dec_err = 1'b1;
          end
        end
      endcase
    end else begin
      dec_err = 1'b1;
    end
  end

  always_comb begin
    rxd_d      = rxd_q;
    rx_c_d     = rx_c_q;
    rx_valid_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (RX_BLOCK_VALID) begin
      rx_valid_d = 1'b1;
      if (block_lock) begin
        rxd_d  = dec_data;
        rx_c_d = dec_ctrl;
        if (dec_err && err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
      end else begin
        rxd_d  = {8{XG_ERROR}};
        rx_c_d = '1;
      end
    end
  end

  always_ff @(posedge RX_CLK or posedge RST) begin
    if (RST) begin
      rxd_q      <= '0;
      rx_c_q     <= '0;
      rx_valid_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rxd_q      <= rxd_d;
      rx_c_q     <= rx_c_d;
      rx_valid_q <= rx_valid_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign RXD        = rxd_q;
  assign RX_C       = rx_c_q;
  assign RX_VALID   = rx_valid_q;
  assign BLOCK_LOCK = block_lock;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_pcs_rx_decoder.sv
// Directed + randomized bench for pcs_rx_decoder with a behavioural model.
module tb_pcs_rx_decoder;

  logic        RX_CLK = 1'b0;
  logic        RST;
  logic [65:0] RX_BLOCK;
  logic        RX_BLOCK_VALID;
  logic [63:0] RXD;
  logic [7:0]  RX_C;
  logic        RX_VALID;
  logic        BLOCK_LOCK;
  logic        SLIP;
  logic [15:0] ERR_CNT;

  pcs_rx_decoder #(
    .LOCK_CNT  (64),
    .WINDOW    (64),
    .BAD_SH_MAX(16),
    .SLIP_WAIT (32)
  ) dut (
    .RX_CLK        (RX_CLK),
    .RST           (RST),
    .RX_BLOCK      (RX_BLOCK),
    .RX_BLOCK_VALID(RX_BLOCK_VALID),
    .RXD           (RXD),
    .RX_C          (RX_C),
    .RX_VALID      (RX_VALID),
    .BLOCK_LOCK    (BLOCK_LOCK),
    .SLIP          (SLIP),
    .ERR_CNT       (ERR_CNT)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the receiver: phase 0 = hunting, 1 = waiting after a slip,
  // 2 = locked, plus the counts the rules refer to.
  int phase, good_run, wait_left, win_blocks, win_bad, m_err;
  bit m_slip;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; good_run = 0; wait_left = 0; win_blocks = 0; win_bad = 0;
    m_err = 0; m_slip = 1'b0;
  endtask

  function automatic void ref_decode(input logic [1:0] hdr, input logic [7:0] bt,
                                     input logic [55:0] pay, output logic [63:0] d,
                                     output logic [7:0] c, output bit err);
    logic [7:0] lane [8];
    logic [7:0] tt [8];
    logic [6:0] ch;
    int n;
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    for (int k = 0; k < 8; k++) lane[k] = 8'hFE;
    c = 8'hFF;
    err = 1'b0;
    if (hdr == 2'b10) begin
      d = {pay, bt};
      c = 8'h00;
      for (int k = 0; k < 8; k++) lane[k] = d[8*k +: 8];
    end else if (hdr == 2'b01) begin
      if (bt == 8'h1E) begin
        for (int k = 0; k < 8; k++) begin
          ch = pay[7*k +: 7];
          if (ch == 7'h00) lane[k] = 8'h07;
          else if (ch == 7'h06) lane[k] = 8'h06;
          else begin
            lane[k] = 8'hFE;
            if (ch != 7'h1E) err = 1'b1;
          end
        end
      end else if (bt == 8'h78) begin
        lane[0] = 8'hFB;
        for (int k = 1; k < 8; k++) lane[k] = pay[8*(k-1) +: 8];
        c = 8'h01;
      end else if (bt == 8'h4B) begin
        lane[0] = 8'h9C;
        for (int k = 1; k < 8; k++) lane[k] = (k < 4) ? pay[8*(k-1) +: 8] : 8'h00;
        c = 8'h01;
      end else begin
        n = -1;
        for (int i = 0; i < 8; i++) if (tt[i] == bt) n = i;
        if (n < 0) err = 1'b1;
        else begin
          for (int k = 0; k < 8; k++) begin
            if (k < n) lane[k] = pay[8*k +: 8];
            else if (k == n) lane[k] = 8'hFD;
            else lane[k] = 8'h07;
            c[k] = (k >= n);
          end
        end
      end
    end else begin
      err = 1'b1;
    end
    for (int k = 0; k < 8; k++) d[8*k +: 8] = lane[k];
  endfunction

  task automatic send(input logic [1:0] hdr, input logic [7:0] bt,
                      input logic [55:0] pay, input bit chk);
    logic [63:0] ed;
    logic [7:0]  ec;
    bit eerr, hv;
    @(negedge RX_CLK);
    RX_BLOCK = {pay, bt, hdr};
    RX_BLOCK_VALID = 1'b1;
    @(posedge RX_CLK);
    #1;
    RX_BLOCK_VALID = 1'b0;
    ref_decode(hdr, bt, pay, ed, ec, eerr);
    if (phase != 2) begin
      ed = {8{8'hFE}}; ec = 8'hFF; eerr = 1'b0;
    end
    if (eerr && m_err != 65535) m_err++;
    hv = (hdr == 2'b10) || (hdr == 2'b01);
    m_slip = 1'b0;
    case (phase)
      0: if (hv) begin
           good_run++;
           if (good_run == 64) begin
             phase = 2; good_run = 0; win_blocks = 0; win_bad = 0;
           end
         end else begin
           m_slip = 1'b1; good_run = 0; wait_left = 32; phase = 1;
         end
      1: begin
           wait_left--;
           if (wait_left == 0) phase = 0;
         end
      default: begin
           win_blocks++;
           if (!hv) win_bad++;
           if (win_bad == 16) begin
             phase = 0; m_slip = 1'b1; win_blocks = 0; win_bad = 0; good_run = 0;
           end else if (win_blocks == 64) begin
             win_blocks = 0; win_bad = 0;
           end
         end
    endcase
    if (chk) begin
      check("rx_valid", 64'(RX_VALID), 64'd1);
      check("rxd", RXD, ed);
      check("rx_c", 64'(RX_C), 64'(ec));
      check("err_cnt", 64'(ERR_CNT), 64'(m_err));
      check("block_lock", 64'(BLOCK_LOCK), 64'(phase == 2));
      check("slip", 64'(SLIP), 64'(m_slip));
    end
  endtask

  task automatic idle();
    @(negedge RX_CLK);
    RX_BLOCK_VALID = 1'b0;
    @(posedge RX_CLK);
    #1;
    m_slip = 1'b0;
    check("idle_rx_valid", 64'(RX_VALID), 64'd0);
    check("idle_slip", 64'(SLIP), 64'd0);
    check("idle_block_lock", 64'(BLOCK_LOCK), 64'(phase == 2));
    check("idle_err_cnt", 64'(ERR_CNT), 64'(m_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rxd"}, RXD, 64'd0);
    check({tag, "_rx_c"}, 64'(RX_C), 64'd0);
    check({tag, "_rx_valid"}, 64'(RX_VALID), 64'd0);
    check({tag, "_block_lock"}, 64'(BLOCK_LOCK), 64'd0);
    check({tag, "_slip"}, 64'(SLIP), 64'd0);
    check({tag, "_err_cnt"}, 64'(ERR_CNT), 64'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    RX_BLOCK_VALID = 1'b0;
    repeat (2) @(posedge RX_CLK);
    #1;
    check_all_zero("reset");
    @(negedge RX_CLK);
    RST = 1'b0;
    model_reset();
  endtask

  function automatic logic [55:0] rpay();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic rand_block(output logic [1:0] hdr, output logic [7:0] bt,
                            output logic [55:0] pay);
    logic [7:0] types [12];
    int r, sel;
    types = '{8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC,
              8'hD2, 8'hE1, 8'hFF, 8'h00};
    r   = $urandom_range(0, 99);
    pay = rpay();
    bt  = 8'($urandom());
    if (r < 5) hdr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    else if (r < 45) hdr = 2'b10;
    else begin
      hdr = 2'b01;
      sel = $urandom_range(0, 11);
      if (sel < 11) bt = types[sel];
      if (bt == 8'h1E) begin
        for (int k = 0; k < 8; k++) begin
          sel = $urandom_range(0, 7);
          pay[7*k +: 7] = (sel < 3) ? 7'h00 : (sel < 5) ? 7'h06 :
                          (sel < 7) ? 7'h1E : 7'($urandom());
        end
      end
    end
  endtask

  task automatic relock();
    int guard = 0;
    while (phase != 2 && guard < 200) begin
      send(2'b10, 8'($urandom()), rpay(), 1'b1);
      guard++;
    end
    check("relock_bound", 64'(phase == 2), 64'd1);
  endtask

  logic [1:0]  h;
  logic [7:0]  t;
  logic [55:0] p;

  initial begin
    RST = 1'b0;
    RX_BLOCK = '0;
    RX_BLOCK_VALID = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Bad header on the 10th block while hunting
    for (int i = 0; i < 9; i++) send(2'b10, 8'($urandom()), rpay(), 1'b1);
    send(2'b11, 8'($urandom()), rpay(), 1'b1);
    check("slip_on_bad_hunt_hdr", 64'(SLIP), 64'd1);
    idle();
    for (int i = 0; i < 32; i++) begin
      rand_block(h, t, p);
      send(h, t, p, 1'b1);
    end
    for (int i = 0; i < 63; i++) send(2'b10, 8'($urandom()), rpay(), 1'b1);
    check("no_lock_after_63", 64'(BLOCK_LOCK), 64'd0);
    send(2'b10, 8'($urandom()), rpay(), 1'b1);
    check("lock_after_64", 64'(BLOCK_LOCK), 64'd1);

    // Start block
    send(2'b01, 8'h78, 56'h00112233445566, 1'b1);
    check("start_rxd", RXD, 64'h00112233445566FB);
    check("start_rx_c", 64'(RX_C), 64'h01);

    // Terminate with four data octets
    send(2'b01, 8'hCC, {24'($urandom()), 32'hDEADBEEF}, 1'b1);
    check("term4_rxd", RXD, 64'h070707FD_DEADBEEF);
    check("term4_rx_c", 64'(RX_C), 64'hF0);

    // 15 bad headers in one window keep lock; the 16th drops it
    for (int i = 0; i < 15; i++) send(2'b00, 8'($urandom()), rpay(), 1'b1);
    check("bad15_lock_kept", 64'(BLOCK_LOCK), 64'd1);
    check("bad15_err_cnt", 64'(ERR_CNT), 64'd15);
    send(2'b11, 8'($urandom()), rpay(), 1'b1);
    check("bad16_lock_lost", 64'(BLOCK_LOCK), 64'd0);
    check("bad16_slip", 64'(SLIP), 64'd1);
    idle();

    // Relock, then 15 bad at the end of one window and 15 at the start of the next
    relock();
    for (int i = 0; i < 49; i++) send(2'b10, 8'($urandom()), rpay(), 1'b1);
    for (int i = 0; i < 30; i++) send(2'b00, 8'($urandom()), rpay(), 1'b1);
    check("bad_split_windows_lock_kept", 64'(BLOCK_LOCK), 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_block(h, t, p);
      send(h, t, p, 1'b1);
    end

    // Drive the error counter to saturation with unknown block types
    relock();
    while (m_err < 65535) send(2'b01, 8'h55, rpay(), 1'b0);
    send(2'b01, 8'h55, rpay(), 1'b1);
    check("sat_err_cnt", 64'(ERR_CNT), 64'hFFFF);
    check("sat_rxd", RXD, {8{8'hFE}});
    check("sat_rx_c", 64'(RX_C), 64'hFF);

    // Asynchronous reset between clock edges
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge RX_CLK);
    RST = 1'b0;
    model_reset();

    // Reset cuts a SLIP pulse short
    send(2'b00, 8'($urandom()), rpay(), 1'b1);
    check("slip_before_rst", 64'(SLIP), 64'd1);
    RST = 1'b1;
    #1;
    check("slip_cut_by_rst", 64'(SLIP), 64'd0);
    @(negedge RX_CLK);
    RST = 1'b0;
    model_reset();

    // Clean lock from reset
    for (int i = 0; i < 64; i++) send(2'b10, 8'($urandom()), rpay(), 1'b1);
    check("clean_lock", 64'(BLOCK_LOCK), 64'd1);
    send(2'b01, 8'h87, rpay(), 1'b1);
    check("term0_rx_c", 64'(RX_C), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
